// File: rtl/imem_load_ctrl_pkg.sv
// Shared constants and controller state encoding for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Host/boot word stream into the instruction-memory loader (valid/ready).
interface imem_load_ctrl_if #(
  parameter int unsigned DATA_W = imem_pkg::DATA_W
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/imem_load_ctrl.sv
// Sequences loads of the instruction SRAM from a host word stream, stalls the CPU
// while the SRAM address mux is in write mode, and keeps a running XOR checksum.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = imem_pkg::ADDR_W,
  parameter int unsigned DATA_W = imem_pkg::DATA_W,
  parameter int unsigned DEPTH  = imem_pkg::DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic [ADDR_W:0]     load_len,
  imem_load_ctrl_if.slave     host,
  output logic                mem_writeEnable,
  output logic [ADDR_W-1:0]   mem_writeAddr,
  output logic [DATA_W-1:0]   mem_instructionInput,
  output logic                cpu_stall,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDR_W:0]     word_count,
  output logic [DATA_W-1:0]   checksum
);

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

  ctrl_state_e     state;
  logic [ADDR_W:0] len_q;
  logic            start_ok;
  logic            accept;
  logic [ADDR_W:0] count_next;

  assign start_ok   = (load_len != '0) && (load_len <= DEPTH_LEN);
  assign accept     = host.s_valid && (state == LOAD);
  assign count_next = word_count + 1'b1;

  assign host.s_ready = (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      len_q                <= '0;
      mem_writeEnable      <= 1'b0;
      mem_writeAddr        <= '0;
      mem_instructionInput <= '0;
      cpu_stall            <= 1'b1;
      load_done            <= 1'b0;
      load_err             <= 1'b0;
      word_count           <= '0;
      checksum             <= '0;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          mem_writeEnable <= 1'b0;
          if (load_start) begin
            if (start_ok) begin
              len_q      <= load_len;
              word_count <= '0;
              checksum   <= '0;
              load_done  <= 1'b0;
              load_err   <= 1'b0;
              cpu_stall  <= 1'b1;
              state      <= LOAD;
            end else begin
              // Rejected request leaves the stall level untouched (IDLE=1, RUN=0).
              load_err <= 1'b1;
            end
          end
        end

        LOAD: begin
          mem_writeEnable <= accept;
          if (accept) begin
            mem_writeAddr        <= word_count[ADDR_W-1:0];
            mem_instructionInput <= host.s_data;
            word_count           <= count_next;
            checksum             <= checksum ^ host.s_data;
            if (count_next == len_q) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // Final write is on the bus this cycle; release the CPU behind it.
          mem_writeEnable <= 1'b0;
          load_done       <= 1'b1;
          cpu_stall       <= 1'b0;
          state           <= RUN;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized scoreboard bench for imem_load_ctrl against a word-level load model.
module tb_imem_load_ctrl;
  import imem_pkg::*;

  localparam int AW    = 11;
  localparam int LW    = AW + 1;
  localparam int DW    = 32;
  localparam int DEPTH = 2048;

  typedef struct {
    int unsigned    due;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          mem_writeEnable;
  logic [AW-1:0] mem_writeAddr;
  logic [DW-1:0] mem_instructionInput;
  logic          cpu_stall;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;
  logic [DW-1:0] checksum;

  imem_load_ctrl_if #(.DATA_W(DW)) hif ();

  imem_load_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .load_start           (load_start),
    .load_len             (load_len),
    .host                 (hif.slave),
    .mem_writeEnable      (mem_writeEnable),
    .mem_writeAddr        (mem_writeAddr),
    .mem_instructionInput (mem_instructionInput),
    .cpu_stall            (cpu_stall),
    .load_done            (load_done),
    .load_err             (load_err),
    .word_count           (word_count),
    .checksum             (checksum)
  );

  always #5 clk = ~clk;

  // Scoreboard and reference model state
  wr_t           exp_q[$];
  wr_t           cur;
  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] img  [DEPTH];
  logic [DW-1:0] wq[$];
  int unsigned   neg_cnt = 0;
  int            tests = 0;
  int            fails = 0;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_data = '0;
  logic          m_stall = 1'b1, m_done = 1'b0, m_err = 1'b0;
  int unsigned   m_wc = 0;
  logic [DW-1:0] m_cs = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write on the SRAM port must match the oldest expected write.
  always @(negedge clk) begin
    neg_cnt++;
    if (mem_writeEnable === 1'b1) begin
      chk("we_implies_stall", 64'(cpu_stall), 64'd1);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_writeAddr, mem_instructionInput);
      end else begin
        cur = exp_q.pop_front();
        chk("write_cycle", 64'(neg_cnt), 64'(cur.due));
        chk("write_addr", 64'(mem_writeAddr), 64'(cur.addr));
        chk("write_data", 64'(mem_instructionInput), 64'(cur.data));
        hold_addr = cur.addr;
        hold_data = cur.data;
        sram[mem_writeAddr] = mem_instructionInput;
      end
    end else begin
      chk("hold_addr", 64'(mem_writeAddr), 64'(hold_addr));
      chk("hold_data", 64'(mem_instructionInput), 64'(hold_data));
      if (exp_q.size() != 0 && exp_q[0].due <= neg_cnt) begin
        cur = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_write: got no write, expected addr %0h data %0h", cur.addr, cur.data);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_ready"}, 64'(hif.s_ready), 64'd0);
    chk({tag, "_stall"}, 64'(cpu_stall), 64'(m_stall));
    chk({tag, "_done"},  64'(load_done), 64'(m_done));
    chk({tag, "_err"},   64'(load_err),  64'(m_err));
    chk({tag, "_wc"},    64'(word_count), 64'(m_wc));
    chk({tag, "_cs"},    64'(checksum),  64'(m_cs));
  endtask

  task automatic bad_start(input int unsigned len);
    load_start  = 1'b1;
    load_len    = LW'(len);
    hif.s_valid = 1'b1;
    hif.s_data  = $urandom;
    tick();
    load_start  = 1'b0;
    hif.s_valid = 1'b0;
    m_err = 1'b1;
    check_status("bad_start");
    tick();
    check_status("bad_start_hold");
  endtask

  // mode 0: s_valid held high, 1: alternating 1,0,..., 2: random with stray load_start.
  // abort_after > 0 stops driving once that many words have been accepted.
  task automatic do_load(input int unsigned len, input int mode, input int unsigned abort_after);
    int unsigned   i = 0;
    int unsigned   k = 0;
    int unsigned   bad = 0;
    logic          v;
    logic [DW-1:0] w;
    load_start = 1'b1;
    load_len   = LW'(len);
    tick();
    load_start = 1'b0;
    m_done = 1'b0; m_err = 1'b0; m_stall = 1'b1; m_wc = 0; m_cs = '0;
    chk("begin_ready", 64'(hif.s_ready), 64'd1);
    chk("begin_stall", 64'(cpu_stall), 64'd1);
    chk("begin_done",  64'(load_done), 64'd0);
    chk("begin_err",   64'(load_err),  64'd0);
    chk("begin_wc",    64'(word_count), 64'd0);
    chk("begin_cs",    64'(checksum),  64'd0);
    while (i < len) begin
      if (abort_after != 0 && i == abort_after) return;
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (k % 2 == 0);
      else                v = 1'($urandom_range(0, 1));
      if (mode == 2 && $urandom_range(0, 7) == 0) begin
        load_start = 1'b1;
        load_len   = LW'($urandom_range(0, 4095));
      end else begin
        load_start = 1'b0;
      end
      if (v && wq.size() != 0) w = wq.pop_front();
      else                     w = $urandom;
      hif.s_valid = v;
      hif.s_data  = w;
      chk("ready_in_load", 64'(hif.s_ready), 64'd1);
      chk("stall_in_load", 64'(cpu_stall), 64'd1);
      if (v) begin
        exp_q.push_back('{neg_cnt + 1, AW'(i), w});
        img[i] = w;
        m_cs ^= w;
        i++;
        m_wc = i;
      end
      k++;
      tick();
    end
    // Final write is presented; further words and requests must be ignored.
    hif.s_valid = 1'($urandom_range(0, 1));
    hif.s_data  = $urandom;
    load_start  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    load_len    = LW'(1);
    chk("drain_ready", 64'(hif.s_ready), 64'd0);
    chk("drain_stall", 64'(cpu_stall), 64'd1);
    chk("drain_done",  64'(load_done), 64'd0);
    tick();
    load_start  = 1'b0;
    hif.s_valid = 1'b0;
    m_stall = 1'b0;
    m_done  = 1'b1;
    check_status("run");
    for (int unsigned a = 0; a < len; a++) begin
      if (sram[a] !== img[a]) bad++;
    end
    chk("readback_mismatches", 64'(bad), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    hif.s_valid = 1'b0;
    hif.s_data  = '0;
    repeat (3) tick();
    check_status("reset");
    chk("reset_we",   64'(mem_writeEnable), 64'd0);
    chk("reset_addr", 64'(mem_writeAddr), 64'd0);
    chk("reset_data", 64'(mem_instructionInput), 64'd0);
    rst = 1'b0;
    tick();

    bad_start(0);
    bad_start(2049);

    wq = '{32'h11, 32'h22, 32'h44, 32'h88};
    do_load(4, 0, 0);
    chk("checksum_ff", 64'(checksum), 64'hFF);

    wq = '{32'h11, 32'h22, 32'h44, 32'h88};
    do_load(4, 1, 0);
    chk("checksum_ff_toggle", 64'(checksum), 64'hFF);

    bad_start(0);

    wq = '{32'hDEADBEEF};
    do_load(1, 0, 0);
    chk("checksum_single", 64'(checksum), 64'hDEADBEEF);

    do_load(2048, 2, 0);
    chk("full_wc", 64'(word_count), 64'd2048);
    chk("full_last_addr", 64'(mem_writeAddr), 64'd2047);

    // Reset after 3 of 8 words, with a competing load_start that reset must win
    do_load(8, 0, 3);
    load_start  = 1'b1;
    load_len    = LW'(4);
    hif.s_valid = 1'b0;
    rst         = 1'b1;
    hold_addr   = '0;
    hold_data   = '0;
    tick();
    load_start = 1'b0;
    m_stall = 1'b1; m_done = 1'b0; m_err = 1'b0; m_wc = 0; m_cs = '0;
    check_status("midload_reset");
    chk("midload_reset_we", 64'(mem_writeEnable), 64'd0);
    chk("midload_reset_q",  64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    tick();
    do_load(2, 0, 0);

    for (int n = 0; n < 6; n++) begin
      do_load($urandom_range(1, 40), n % 3, 0);
      if ($urandom_range(0, 1) == 1) bad_start($urandom_range(2049, 4095));
    end

    repeat (3) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
